motor_drive_sequencer: RTL
==========================

// Module: motor_drive_sequencer
// PURPOSE
// - Sits between the serial Receiver's command decode and the motor driver pins.
// - Turns each decoded command strobe into registered Len/Ldir/Ren/Rdir drive levels.
// - Inserts an enable-low dead time on every direction reversal.
// - A link watchdog stops both motors when frames stop arriving.
// PARAMETERS
// - DEADTIME_CYCLES  4     Clk_In cycles enable is held low on a reversal. Must be >= 1.
// - WATCHDOG_CYCLES  1024  Idle cycles without Cmd_Valid before a forced stop. Must be >= 2.
// - CNT_W            8     Width of Cmd_Count.
// PORTS
// - Clk_In      in   1      System clock, rising edge.
// - Reset_In    in   1      Synchronous, active-high reset.
// - Cmd_Valid   in   1      One-cycle strobe: Cmd_In holds a new decoded command.
// - Cmd_In      in   4      {L_en, L_dir, R_en, R_dir} requested drive.
// - Len         out  1      Left motor enable.
// - Ldir        out  1      Left motor direction.
// - Ren         out  1      Right motor enable.
// - Rdir        out  1      Right motor direction.
// - Timeout     out  1      High while the watchdog has expired.
// - Cmd_Count   out  CNT_W  Count of accepted commands; wraps.
// BEHAVIOUR
// - Reset values:
//   - Len/Ldir/Ren/Rdir = 0, Timeout = 0, Cmd_Count = 0.
//   - Watchdog counter = 0; both channels in STOP; targets = 0.
//   - Reset wins over Cmd_Valid on the same edge.
// - All outputs are registered.
//   - Cmd_Valid sampled at edge k: the resulting state and outputs are visible after edge k (1-cycle latency).
// - Each side (L, R) runs an independent FSM: STOP, RUN, DEAD.
// - STOP (en=0, dir holds its last value):
//   - Accepted command with en=1 -> RUN, en=1, dir=requested dir.
// - RUN (en=1):
//   - en=0 -> STOP.
//   - Same dir -> stay in RUN.
//   - Opposite dir -> DEAD: en=0, old dir held, dead counter cleared.
// - DEAD (en=0, old dir held):
//   - Lasts exactly DEADTIME_CYCLES cycles.
//   - At expiry, target en=1 -> RUN: en=1 and dir=target dir on the same edge.
//   - At expiry, target en=0 -> STOP.
//   - A new command during DEAD updates the target. The counter does not restart.
//   - A new command with en=0 during DEAD -> STOP immediately.
// - Watchdog:
//   - Counts cycles since the last Cmd_Valid; cleared on Cmd_Valid.
//   - Reaching WATCHDOG_CYCLES-1 -> Timeout=1; both targets forced to en=0; every channel goes to STOP.
//   - A channel in DEAD drops straight to STOP.
//   - Timeout stays high and the counter saturates until the next Cmd_Valid.
//   - That Cmd_Valid clears Timeout on the same edge and is executed normally.
//   - Cmd_Valid on the expiry edge: the command wins and Timeout stays 0.
// - Cmd_Count increments on each accepted Cmd_Valid and wraps from 2^CNT_W-1 to 0.
//   - Commands arriving during DEAD or Timeout still count.
// STRUCTURE
// - Shared package/include:
//   - Channel state encodings (STOP=2'd0, RUN=2'd1, DEAD=2'd2).
//   - Cmd_In bit positions (L_EN=3, L_DIR=2, R_EN=1, R_DIR=0).
// - Sub-module motor_channel_ctrl:
//   - One per side; holds the FSM, target register and dead counter.
//   - Inputs: cmd_valid, en_req, dir_req, force_stop.
//   - Outputs: en, dir.
// - Top level: watchdog, Cmd_Count, and two motor_channel_ctrl instances.
// TESTING
// - Bench parameters: DEADTIME_CYCLES=4, WATCHDOG_CYCLES=64, 10 ns clock.
// - Reset with Cmd_Valid pulsing, Cmd_In=4'b1111 -> all outputs 0 throughout reset; Cmd_Count=0 after release.
// - Cmd_In=4'b1010 strobed at edge k -> after edge k Len=1, Ldir=0, Ren=1, Rdir=0; Cmd_Count=1.
// - From RUN 4'b1010, strobe 4'b1110:
//   - Len=0 for exactly 4 cycles with Ldir=0, then Len=1 and Ldir=1 together.
//   - Ren/Rdir unchanged (1/0) throughout.
// - Mid-DEAD (cycle 2), strobe 4'b0010 -> Len=0 next cycle and stays 0 (STOP); Ren=1.
// - No strobe for 63 cycles after the last command:
//   - Timeout=1 and all enables 0.
//   - Strobe 4'b0011 -> Timeout=0, Ren=1, Rdir=1, Len=0 on the next cycle.
// - Cmd_Valid on the watchdog expiry edge -> Timeout stays 0 and the command is applied.
// - 256 consecutive strobes -> Cmd_Count wraps to 0.

Source files
------------

// File: rtl/motor_drive_sequencer_pkg.sv
// Shared encodings for the motor drive sequencer: channel FSM states and
// the bit layout of the decoded command word.
package motor_drive_sequencer_pkg;

  typedef enum logic [1:0] {
    CH_STOP = 2'd0,
    CH_RUN  = 2'd1,
    CH_DEAD = 2'd2
  } ch_state_e;

  localparam int L_EN  = 3;
  localparam int L_DIR = 2;
  localparam int R_EN  = 1;
  localparam int R_DIR = 0;

endpackage

// File: rtl/motor_drive_sequencer_channel.sv
// One motor side: STOP/RUN/DEAD sequencing with a latched target so a
// reversal always passes through an enable-low dead time.
module motor_channel_ctrl
  import motor_drive_sequencer_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic en_req,
  input  logic dir_req,
  input  logic force_stop,
  output logic en,
  output logic dir
);

  localparam int DCW = $clog2(DEADTIME_CYCLES + 1);
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEADTIME_CYCLES - 1);

  ch_state_e      state_q, state_d;
  logic           en_q, en_d;
  logic           dir_q, dir_d;
  logic           tgt_en_q, tgt_en_d;
  logic           tgt_dir_q, tgt_dir_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CH_STOP;
      en_q      <= 1'b0;
      dir_q     <= 1'b0;
      tgt_en_q  <= 1'b0;
      tgt_dir_q <= 1'b0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      dir_q     <= dir_d;
      tgt_en_q  <= tgt_en_d;
      tgt_dir_q <= tgt_dir_d;
      dcnt_q    <= dcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    dir_d     = dir_q;
    tgt_en_d  = tgt_en_q;
    tgt_dir_d = tgt_dir_q;
    dcnt_d    = dcnt_q;
    if (cmd_valid) begin
      tgt_en_d  = en_req;
      tgt_dir_d = dir_req;
    end
    if (force_stop) begin
      state_d  = CH_STOP;
      en_d     = 1'b0;
      tgt_en_d = 1'b0;
    end else begin
      unique case (state_q)
        CH_STOP: begin
          if (cmd_valid && en_req) begin
            state_d = CH_RUN;
            en_d    = 1'b1;
            dir_d   = dir_req;
          end
        end
        CH_RUN: begin
          if (cmd_valid) begin
            if (!en_req) begin
              state_d = CH_STOP;
              en_d    = 1'b0;
            end else if (dir_req != dir_q) begin
              state_d = CH_DEAD;
              en_d    = 1'b0;
              dcnt_d  = '0;
            end
          end
        end
        CH_DEAD: begin
          // Old dir stays on the pin; the new one is applied with enable.
          if (cmd_valid && !en_req) begin
            state_d = CH_STOP;
          end else if (dcnt_q == DEAD_LAST) begin
            if (tgt_en_d) begin
              state_d = CH_RUN;
              en_d    = 1'b1;
              dir_d   = tgt_dir_d;
            end else begin
              state_d = CH_STOP;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = CH_STOP;
          en_d    = 1'b0;
        end
      endcase
    end
  end

  assign en  = en_q;
  assign dir = dir_q;

endmodule

// File: rtl/motor_drive_sequencer.sv
// Command strobe to motor pin sequencer: link watchdog, accepted-command
// counter and one channel controller per motor side.
module motor_drive_sequencer
  import motor_drive_sequencer_pkg::*;
#(
  parameter int DEADTIME_CYCLES = 4,
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int CNT_W           = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Cmd_Valid,
  input  logic [3:0]       Cmd_In,
  output logic             Len,
  output logic             Ldir,
  output logic             Ren,
  output logic             Rdir,
  output logic             Timeout,
  output logic [CNT_W-1:0] Cmd_Count
);

  localparam int WDW = $clog2(WATCHDOG_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WATCHDOG_CYCLES - 1);
  localparam logic [WDW-1:0] WD_PRE  = WDW'(WATCHDOG_CYCLES - 2);

  logic [WDW-1:0]   wd_q, wd_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_stop;

  // Asserted on the edge the counter reaches its last value and while saturated.
  assign force_stop = !Cmd_Valid && (wd_q >= WD_PRE);

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    if (Cmd_Valid) begin
      wd_d      = '0;
      timeout_d = 1'b0;
      cnt_d     = cnt_q + 1'b1;
    end else begin
      if (wd_q != WD_LAST) wd_d = wd_q + 1'b1;
      if (force_stop) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  motor_channel_ctrl #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_left (
    .clk        (Clk_In),
    .rst        (Reset_In),
    .cmd_valid  (Cmd_Valid),
    .en_req     (Cmd_In[L_EN]),
    .dir_req    (Cmd_In[L_DIR]),
    .force_stop (force_stop),
    .en         (Len),
    .dir        (Ldir)
  );

  motor_channel_ctrl #(.DEADTIME_CYCLES(DEADTIME_CYCLES)) u_right (
    .clk        (Clk_In),
    .rst        (Reset_In),
    .cmd_valid  (Cmd_Valid),
    .en_req     (Cmd_In[R_EN]),
    .dir_req    (Cmd_In[R_DIR]),
    .force_stop (force_stop),
    .en         (Ren),
    .dir        (Rdir)
  );

  assign Timeout   = timeout_q;
  assign Cmd_Count = cnt_q;

endmodule
